// File: rtl/sub_bytes_pkg.sv
// Shared constants for the SubBytes engine: FSM state encodings, the forward
// S-box table and, when SBOX_INV_EN is defined, the inverse S-box table.
package sub_bytes_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Chunk counter width: clog2 of the chunk count, never narrower than one bit.
   function automatic int cnt_width(input int chunks);
      if (chunks > 32'sd1) begin
         return $clog2(chunks);
      end else begin
         return 32'sd1;
      end
   endfunction

   localparam logic [7:0] SBOX_FWD [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

`ifdef SBOX_INV_EN
   localparam logic [7:0] SBOX_INV [0:255] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };
`endif

endpackage

// File: rtl/sub_bytes_unit_sbox_lut.sv
// Single combinational S-box lookup. The mode input selects the inverse
// table only when SBOX_INV_EN is defined; otherwise the lookup is forward-only.
module sbox_lut
   import sub_bytes_pkg::*;
(
   input  logic [7:0] byte_val,
   input  logic       mode,
   output logic [7:0] sub_val
);

`ifdef SBOX_INV_EN
   // Table select between forward and inverse substitution.
   always_comb begin
      if (mode) begin
         sub_val = SBOX_INV[byte_val];
      end else begin
         sub_val = SBOX_FWD[byte_val];
      end
   end
`else
   logic unused_mode_s;
   assign unused_mode_s = mode;

   // Forward substitution only.
   always_comb begin
      sub_val = SBOX_FWD[byte_val];
   end
`endif

endmodule

// File: rtl/sub_bytes_unit.sv
// Time-multiplexed AES SubBytes/InvSubBytes engine, NUM_SBOX bytes per cycle.
// Define SBOX_INV_EN to build the inverse table and honour iInv.
module sub_bytes_unit
   import sub_bytes_pkg::*;
#(
   parameter int NUM_BYTES = 32'sd16,
   parameter int NUM_SBOX  = 32'sd4
)(
   input  logic                   iClk,
   input  logic                   iRst,
   input  logic                   iValid,
   output logic                   oReady,
   input  logic                   iInv,
   input  logic [8*NUM_BYTES-1:0] iData,
   output logic                   oValid,
   input  logic                   iReady,
   output logic [8*NUM_BYTES-1:0] oData
);

   localparam int CHUNKS  = NUM_BYTES / NUM_SBOX;
   localparam int CW      = cnt_width(CHUNKS);
   localparam int CHUNK_W = 8 * NUM_SBOX;

   if (NUM_BYTES < 32'sd1 || NUM_SBOX < 32'sd1 || NUM_SBOX > NUM_BYTES ||
       (NUM_BYTES % NUM_SBOX) != 32'sd0) begin : g_bad_cfg
      $error("sub_bytes_unit: NUM_SBOX must divide NUM_BYTES and lie in 1..NUM_BYTES");
   end

   logic [1:0]             state_r;
   logic [CW-1:0]          cnt_r;
   logic                   mode_r;
   logic [8*NUM_BYTES-1:0] work_r;
   logic [CHUNK_W-1:0]     chunk_s;
   logic [CHUNK_W-1:0]     sub_s;
   logic                   mode_in_s;

`ifdef SBOX_INV_EN
   assign mode_in_s = iInv;
`else
   logic unused_inv_s;
   assign unused_inv_s = iInv;
   assign mode_in_s    = 1'b0;
`endif

   // Select the chunk addressed by the counter for the shared lookups.
   always_comb begin
      chunk_s = '0;
      for (int k = 0; k < CHUNKS; k++) begin
         chunk_s = chunk_s | ((cnt_r == CW'(k)) ? work_r[k*CHUNK_W +: CHUNK_W] : {CHUNK_W{1'b0}});
      end
   end

   for (genvar g = 0; g < NUM_SBOX; g++) begin : g_lut
      sbox_lut u_lut (
         .byte_val (chunk_s[8*g +: 8]),
         .mode     (mode_r),
         .sub_val  (sub_s[8*g +: 8])
      );
   end

   // FSM, chunk counter, mode flag and work register; reset wins over handshakes.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         mode_r  <= 1'b0;
         work_r  <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (iValid) begin
                  work_r  <= iData;
                  mode_r  <= mode_in_s;
                  cnt_r   <= '0;
                  state_r <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               for (int k = 0; k < CHUNKS; k++) begin
                  if (cnt_r == CW'(k)) begin
                     work_r[k*CHUNK_W +: CHUNK_W] <= sub_s;
                  end
               end
               if (cnt_r == CW'(CHUNKS - 1)) begin
                  cnt_r   <= '0;
                  state_r <= ST_DONE;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            ST_DONE: begin
               if (iReady) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs decode straight from the state register; data is masked outside DONE.
   assign oReady = ~iRst & (state_r == ST_IDLE);
   assign oValid = (state_r == ST_DONE);
   assign oData  = (state_r == ST_DONE) ? work_r : {(8*NUM_BYTES){1'b0}};

endmodule

// File: tb/tb_sub_bytes_unit.sv
// Scoreboard bench for sub_bytes_unit: default 16/4 instance plus the
// 16/16, 16/1, 4/4 and 4/2 configurations; S-box reference is computed in GF(2^8).
module tb_sub_bytes_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [4:0]   ival, iinv, ird;
   logic [4:0]   ordy, ov;
   logic [127:0] din [5];
   logic [127:0] dout0, dout1, dout2;
   logic [31:0]  dout3, dout4;

   sub_bytes_unit dut (
      .iClk(clk), .iRst(rst), .iValid(ival[0]), .oReady(ordy[0]), .iInv(iinv[0]),
      .iData(din[0]), .oValid(ov[0]), .iReady(ird[0]), .oData(dout0));
   sub_bytes_unit #(.NUM_BYTES(16), .NUM_SBOX(16)) dut_16_16 (
      .iClk(clk), .iRst(rst), .iValid(ival[1]), .oReady(ordy[1]), .iInv(iinv[1]),
      .iData(din[1]), .oValid(ov[1]), .iReady(ird[1]), .oData(dout1));
   sub_bytes_unit #(.NUM_BYTES(16), .NUM_SBOX(1)) dut_16_1 (
      .iClk(clk), .iRst(rst), .iValid(ival[2]), .oReady(ordy[2]), .iInv(iinv[2]),
      .iData(din[2]), .oValid(ov[2]), .iReady(ird[2]), .oData(dout2));
   sub_bytes_unit #(.NUM_BYTES(4), .NUM_SBOX(4)) dut_4_4 (
      .iClk(clk), .iRst(rst), .iValid(ival[3]), .oReady(ordy[3]), .iInv(iinv[3]),
      .iData(din[3][31:0]), .oValid(ov[3]), .iReady(ird[3]), .oData(dout3));
   sub_bytes_unit #(.NUM_BYTES(4), .NUM_SBOX(2)) dut_4_2 (
      .iClk(clk), .iRst(rst), .iValid(ival[4]), .oReady(ordy[4]), .iInv(iinv[4]),
      .iData(din[4][31:0]), .oValid(ov[4]), .iReady(ird[4]), .oData(dout4));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_cyc [5];
   logic [4:0]   pending = 5'd0;
   logic [4:0]   ov_prev = 5'd0;
   logic [127:0] sb_q [$];
   logic [7:0]   fwd_tab [256];
   logic [7:0]   inv_tab [256];
   logic [127:0] d_v;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      logic       hi;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b  = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic build_tables();
      logic [7:0] y, s;
      for (int x = 0; x < 256; x++) begin
         y = 8'h00;
         for (int c = 1; c < 256; c++) begin
            if (gmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
         end
         s = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
         fwd_tab[x] = s;
         inv_tab[s] = 8'(x);
      end
   endtask

   function automatic int nbytes_of(input int u);
      return (u >= 3) ? 4 : 16;
   endfunction

   function automatic int lat_of(input int u);
      case (u)
         0: return 4;
         1: return 1;
         2: return 16;
         3: return 1;
         default: return 2;
      endcase
   endfunction

   function automatic logic [127:0] dout_of(input int u);
      case (u)
         0: return dout0;
         1: return dout1;
         2: return dout2;
         3: return {96'h0, dout3};
         default: return {96'h0, dout4};
      endcase
   endfunction

   function automatic logic [127:0] model(input int u, input logic [127:0] data, input logic inv);
      logic [127:0] r;
      logic [7:0]   b;
      r = '0;
      for (int i = 0; i < nbytes_of(u); i++) begin
         b = data[8*i +: 8];
`ifdef SBOX_INV_EN
         r[8*i +: 8] = inv ? inv_tab[b] : fwd_tab[b];
`else
         r[8*i +: 8] = fwd_tab[b];
`endif
      end
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Protocol and scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      for (int u = 0; u < 5; u++) begin
         d_v = dout_of(u);
         if (rst) begin
            check_eq("rdy_in_reset", ordy[u], 0);
            check_eq("vld_in_reset", ov[u], 0);
         end else if (pending[u]) begin
            check_eq("rdy_busy", ordy[u], 0);
            if (ov[u]) begin
               if (!ov_prev[u]) check_eq("latency", cyc - acc_cyc[u], lat_of(u));
               if (sb_q.size() == 0) begin
                  check_eq("sb_empty_on_out", 1, 0);
               end else begin
                  check_eq("data", d_v, sb_q[0]);
                  if (ird[u]) begin
                     void'(sb_q.pop_front());
                     pending[u] = 1'b0;
                  end
               end
            end else begin
               check_eq("data_busy_zero", d_v, 0);
            end
         end else begin
            check_eq("rdy_idle", ordy[u], 1);
            check_eq("vld_idle", ov[u], 0);
            check_eq("data_idle_zero", d_v, 0);
         end
         ov_prev[u] = ov[u];
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int u, input logic [127:0] data, input logic inv,
                       input logic [127:0] exp, output int waits);
      din[u]  = data;
      iinv[u] = inv;
      ival[u] = 1'b1;
      waits   = 0;
      do begin
         @(negedge clk);
         waits++;
      end while (!ordy[u] && waits < 200);
      if (!ordy[u]) begin
         check_eq("accept_timeout", 0, 1);
         ival[u] = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         ival[u] = 1'b0;
         sb_q.push_back(exp);
         pending[u]  = 1'b1;
         acc_cyc[u]  = cyc;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || pending != 5'd0) && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      check_eq("drain_timeout", (sb_q.size() != 0 || pending != 5'd0), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int           w;
      logic [127:0] stim, exp, blk_a, blk_b;
      logic         inv;
      build_tables();
      rst  = 1'b1;
      ival = 5'd0;
      iinv = 5'd0;
      ird  = 5'd0;
      for (int u = 0; u < 5; u++) din[u] = '0;
      cycles(3);
      rst = 1'b0;

      // Directed vectors on the default instance.
      ird[0] = 1'b1;
      send(0, 128'h0, 1'b0, {16{8'h63}}, w);
      drain();
      stim = {{12{8'h00}}, 8'hbe, 8'he3, 8'h3d, 8'h19};
      exp  = {{12{8'h63}}, 8'hae, 8'h11, 8'h27, 8'hd4};
      send(0, stim, 1'b0, exp, w);
      drain();
      stim = {{13{8'h63}}, 8'h7c, 8'hed, 8'h63};
`ifdef SBOX_INV_EN
      exp  = {{13{8'h00}}, 8'h01, 8'h53, 8'h00};
`else
      exp  = {{13{8'hfb}}, 8'h10, 8'h55, 8'hfb};
`endif
      send(0, stim, 1'b1, exp, w);
      drain();

      // Backpressure in DONE, with a competing request that must wait.
      ird[0] = 1'b0;
      blk_a  = {$urandom, $urandom, $urandom, $urandom};
      blk_b  = {$urandom, $urandom, $urandom, $urandom};
      send(0, blk_a, 1'b0, model(0, blk_a, 1'b0), w);
      cycles(9);
      din[0]  = blk_b;
      iinv[0] = 1'b0;
      ival[0] = 1'b1;
      cycles(3);
      ird[0] = 1'b1;
      send(0, blk_b, 1'b0, model(0, blk_b, 1'b0), w);
      check_eq("accept_after_release", w, 2);
      drain();

      // Reset pulse while chunk 2 would be written aborts the block.
      blk_a = {$urandom, $urandom, $urandom, $urandom};
      send(0, blk_a, 1'b0, model(0, blk_a, 1'b0), w);
      cycles(2);
      rst = 1'b1;
      sb_q.delete();
      pending = 5'd0;
      cycles(1);
      rst = 1'b0;
      cycles(10);
      blk_b = {$urandom, $urandom, $urandom, $urandom};
      send(0, blk_b, 1'b1, model(0, blk_b, 1'b1), w);
      drain();

      // Random back-to-back blocks over every configuration.
      for (int u = 0; u < 5; u++) begin
         ird[u] = 1'b1;
         for (int n = 0; n < 6; n++) begin
            stim = {$urandom, $urandom, $urandom, $urandom};
            if (u >= 3) stim[127:32] = '0;
            inv = 1'($urandom_range(0, 1));
            send(u, stim, inv, model(u, stim, inv), w);
         end
         drain();
         ird[u] = 1'b0;
      end

      check_eq("sb_leftover", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
